// File: rtl/viterbi_pkg.sv
// Shared constants and trellis tables for the K=3 rate-1/2 (7,5) Viterbi decoder.
package viterbi_pkg;

  localparam int BM_W       = 2;
  localparam int NUM_STATES = 4;
  localparam int PM_W_DEF   = 6;

  typedef logic [PM_W_DEF-1:0] pm_t;

  // Packed tables, index n = next state (entry 0 is the rightmost element).
  localparam logic [NUM_STATES-1:0][1:0] PRED0 = {2'd2, 2'd0, 2'd2, 2'd0};
  localparam logic [NUM_STATES-1:0][1:0] PRED1 = {2'd3, 2'd1, 2'd3, 2'd1};
  localparam logic [NUM_STATES-1:0][1:0] SYM0  = {2'd1, 2'd3, 2'd2, 2'd0};
  localparam logic [NUM_STATES-1:0][1:0] SYM1  = {2'd2, 2'd0, 2'd1, 2'd3};

endpackage

// File: rtl/acs_cell.sv
// Combinational add-compare-select for one trellis state; ties favour the even predecessor.
module acs_cell
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEF
) (
  input  logic [PM_W-1:0] i_pm_0,
  input  logic [PM_W-1:0] i_pm_1,
  input  logic [BM_W-1:0] i_bm_0,
  input  logic [BM_W-1:0] i_bm_1,
  output logic [PM_W-1:0] o_pm,
  output logic            o_dec
);

  logic [PM_W:0] cand_0;
  logic [PM_W:0] cand_1;

  always_comb begin
    cand_0 = {1'b0, i_pm_0} + {{(PM_W + 1 - BM_W){1'b0}}, i_bm_0};
    cand_1 = {1'b0, i_pm_1} + {{(PM_W + 1 - BM_W){1'b0}}, i_bm_1};
    o_dec  = (cand_1 < cand_0);
    // Normalisation keeps every survivor below 2**PM_W, so the carry bit is only needed for the compare.
    o_pm   = o_dec ? cand_1[PM_W-1:0] : cand_0[PM_W-1:0];
  end

endmodule

// File: rtl/path_metric_unit.sv
// ACS stage: path metric registers, normalisation, start/reset loading and survivor decisions.
// Optional macro PMU_BEST_STATE_EN adds the registered argmin of the path metrics on o_best_state.
module path_metric_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W    = PM_W_DEF,
  parameter int INIT_PM = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_valid,
  input  logic [1:0]      i_BM_0,
  input  logic [1:0]      i_BM_1,
  input  logic [1:0]      i_BM_2,
  input  logic [1:0]      i_BM_3,
  output logic            o_valid,
  output logic [3:0]      o_dec,
  output logic [PM_W-1:0] o_PM_0,
  output logic [PM_W-1:0] o_PM_1,
  output logic [PM_W-1:0] o_PM_2,
  output logic [PM_W-1:0] o_PM_3,
  output logic [1:0]      o_best_state
);

  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

  logic [BM_W-1:0]       bm       [NUM_STATES];
  logic [PM_W-1:0]       pm_q     [NUM_STATES];
  logic [PM_W-1:0]       pm_d     [NUM_STATES];
  logic [PM_W-1:0]       pm_src   [NUM_STATES];
  logic [PM_W-1:0]       acs_pm   [NUM_STATES];
  logic [PM_W-1:0]       norm_pm  [NUM_STATES];
  logic [NUM_STATES-1:0] acs_dec;
  logic [NUM_STATES-1:0] dec_q, dec_d;
  logic                  valid_q, valid_d;
  logic                  norm;

  assign bm[0] = i_BM_0;
  assign bm[1] = i_BM_1;
  assign bm[2] = i_BM_2;
  assign bm[3] = i_BM_3;

  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      pm_src[i] = i_start ? ((i == 0) ? '0 : INIT_V) : pm_q[i];
    end
  end

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    acs_cell #(.PM_W(PM_W)) u_acs (
      .i_pm_0 (pm_src[PRED0[n]]),
      .i_pm_1 (pm_src[PRED1[n]]),
      .i_bm_0 (bm[SYM0[n]]),
      .i_bm_1 (bm[SYM1[n]]),
      .o_pm   (acs_pm[n]),
      .o_dec  (acs_dec[n])
    );
  end

  always_comb begin
    norm = 1'b1;
    for (int i = 0; i < NUM_STATES; i++) begin
      norm = norm & acs_pm[i][PM_W-1];
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      norm_pm[i] = acs_pm[i];
      if (norm) norm_pm[i][PM_W-1] = 1'b0;
    end

    pm_d    = pm_q;
    dec_d   = dec_q;
    valid_d = 1'b0;
    if (i_valid) begin
      pm_d    = norm_pm;
      dec_d   = acs_dec;
      valid_d = 1'b1;
    end else if (i_start) begin
      pm_d = pm_src;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i] <= (i == 0) ? '0 : INIT_V;
      end
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pm_q    <= pm_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_dec   = dec_q;
  assign o_PM_0  = pm_q[0];
  assign o_PM_1  = pm_q[1];
  assign o_PM_2  = pm_q[2];
  assign o_PM_3  = pm_q[3];

`ifdef PMU_BEST_STATE_EN
  logic [1:0]      best_q, best_d;
  logic [1:0]      idx_01, idx_23;
  logic [PM_W-1:0] min_01, min_23;

  // Pairwise tree; strict compares keep the lower index on ties.
  always_comb begin
    idx_01 = (norm_pm[1] < norm_pm[0]) ? 2'd1 : 2'd0;
    min_01 = (norm_pm[1] < norm_pm[0]) ? norm_pm[1] : norm_pm[0];
    idx_23 = (norm_pm[3] < norm_pm[2]) ? 2'd3 : 2'd2;
    min_23 = (norm_pm[3] < norm_pm[2]) ? norm_pm[3] : norm_pm[2];
    best_d = best_q;
    if (i_valid) best_d = (min_23 < min_01) ? idx_23 : idx_01;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) best_q <= 2'd0;
    else       best_q <= best_d;
  end

  assign o_best_state = best_q;
`else
  assign o_best_state = 2'd0;
`endif

endmodule

// File: tb/tb_path_metric_unit.sv
// Self-checking bench for path_metric_unit: directed trellis cases plus randomized frames vs. a code-level model.
// Define PMU_BEST_STATE_EN for both bench and RTL to check the best-state output.
module tb_path_metric_unit;

  localparam int PM_W    = 6;
  localparam int INIT_PM = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, valid;
  logic [1:0] bm0, bm1, bm2, bm3;
  logic       o_valid;
  logic [3:0] o_dec;
  logic [PM_W-1:0] o_pm0, o_pm1, o_pm2, o_pm3;
  logic [1:0] o_best;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  int m_pm [4];
  int m_dec, m_valid, m_best;

  always #5 clk = ~clk;

  path_metric_unit #(.PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
    .i_BM_0(bm0), .i_BM_1(bm1), .i_BM_2(bm2), .i_BM_3(bm3),
    .o_valid(o_valid), .o_dec(o_dec),
    .o_PM_0(o_pm0), .o_PM_1(o_pm1), .o_PM_2(o_pm2), .o_PM_3(o_pm3),
    .o_best_state(o_best)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_best(input int b);
`ifdef PMU_BEST_STATE_EN
    return b;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    m_pm[0] = 0;
    for (int i = 1; i < 4; i++) m_pm[i] = INIT_PM;
    m_dec = 0; m_valid = 0; m_best = 0;
  endfunction

  // Code symbol on the branch from state s under input u, generators 7 (111) and 5 (101).
  function automatic int branch_sym(input int s, input int u);
    int u1, u2, c0, c1;
    u1 = (s >> 1) & 1;
    u2 = s & 1;
    c0 = u ^ u1 ^ u2;
    c1 = u ^ u2;
    return c0 * 2 + c1;
  endfunction

  function automatic void model_step(input bit st, input bit vl, input int bm [4]);
    int src [4];
    int nw [4];
    int dec, all_hi, bst;
    for (int i = 0; i < 4; i++) src[i] = st ? ((i == 0) ? 0 : INIT_PM) : m_pm[i];
    if (!vl) begin
      m_valid = 0;
      if (st) m_pm = src;
      return;
    end
    dec = 0;
    for (int n = 0; n < 4; n++) begin
      int u, pe, po, ce, co;
      u  = n >> 1;
      pe = (n & 1) * 2;
      po = pe + 1;
      ce = src[pe] + bm[branch_sym(pe, u)];
      co = src[po] + bm[branch_sym(po, u)];
      if (co < ce) begin dec |= (1 << n); nw[n] = co; end
      else nw[n] = ce;
    end
    all_hi = 1;
    for (int n = 0; n < 4; n++) if (nw[n] < 32 || nw[n] >= 64) all_hi = 0;
    if (all_hi) for (int n = 0; n < 4; n++) nw[n] -= 32;
    bst = 0;
    for (int n = 1; n < 4; n++) if (nw[n] < nw[bst]) bst = n;
    m_pm = nw; m_dec = dec; m_valid = 1; m_best = bst;
  endfunction

  task automatic step(input bit st, input bit vl, input int b0, input int b1, input int b2, input int b3);
    int bm [4];
    @(negedge clk);
    start = st; valid = vl;
    bm0 = 2'(b0); bm1 = 2'(b1); bm2 = 2'(b2); bm3 = 2'(b3);
    bm[0] = b0; bm[1] = b1; bm[2] = b2; bm[3] = b3;
    @(posedge clk);
    model_step(st, vl, bm);
    #1;
  endtask

  task automatic step_rx(input bit st, input bit vl, input int rx);
    int d [4];
    for (int k = 0; k < 4; k++) d[k] = $countones(2'(rx ^ k));
    step(st, vl, d[0], d[1], d[2], d[3]);
  endtask

  task automatic chk_lit(input string name, input int v, input int p0, input int p1, input int p2,
                         input int p3, input int dec, input int best);
    chk({name, ".valid"}, o_valid, v);
    chk({name, ".pm0"}, o_pm0, p0);
    chk({name, ".pm1"}, o_pm1, p1);
    chk({name, ".pm2"}, o_pm2, p2);
    chk({name, ".pm3"}, o_pm3, p3);
    chk({name, ".dec"}, o_dec, dec);
    chk({name, ".best"}, o_best, exp_best(best));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 0; valid = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("cmp.valid", o_valid, m_valid);
      chk("cmp.dec", o_dec, m_dec);
      chk("cmp.pm0", o_pm0, m_pm[0]);
      chk("cmp.pm1", o_pm1, m_pm[1]);
      chk("cmp.pm2", o_pm2, m_pm[2]);
      chk("cmp.pm3", o_pm3, m_pm[3]);
      chk("cmp.best", o_best, exp_best(m_best));
    end
  end

  initial begin
    rst = 1'b1; start = 0; valid = 0; bm0 = 0; bm1 = 0; bm2 = 0; bm3 = 0;
    model_reset();
    #12;
    chk_lit("reset", 0, 0, 8, 8, 8, 0, 0);
    do_reset();
    chk_en = 1;

    step(1, 1, 0, 1, 1, 2);
    chk_lit("t1", 1, 0, 9, 2, 9, 0, 0);
    step(0, 1, 0, 1, 1, 2);
    chk_lit("t2", 1, 0, 3, 2, 3, 0, 0);

    do_reset();
    step(1, 1, 2, 1, 1, 0);
    chk_lit("t3", 1, 2, 9, 0, 9, 0, 2);

    do_reset();
    step(1, 1, 0, 0, 0, 0);
    chk_lit("t4a", 1, 0, 8, 0, 8, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk_lit("t4b", 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 3, 0);
    chk_lit("t4c", 1, 0, 0, 0, 0, 3, 0);

    for (int c = 1; c <= 11; c++) begin
      step(0, 1, 3, 3, 3, 3);
      if (c == 10) chk_lit("t5_c10", 1, 30, 30, 30, 30, 0, 0);
    end
    chk_lit("t5_c11", 1, 1, 1, 1, 1, 0, 0);

    step(0, 0, 2, 1, 0, 3);
    step(0, 0, 1, 1, 1, 1);
    chk_lit("gap", 0, 1, 1, 1, 1, 0, 0);

    step_rx(0, 1, 2);
    step_rx(0, 1, 1);
    step(1, 0, 3, 3, 3, 3);
    chk_lit("start_novalid", 0, 0, 8, 8, 8, m_dec, m_best);

    step_rx(0, 1, 3);
    step_rx(0, 1, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_lit("async_rst", 0, 0, 8, 8, 8, 0, 0);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 400; c++) begin
      bit st, vl;
      st = ($urandom_range(0, 39) == 0);
      vl = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0)
        step(st, vl, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        step_rx(st, vl, $urandom_range(0, 3));
    end

    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
